sc_width_conv_fifo: RTL

//  Single-clock FIFO with wide write / narrow read width conversion. Generalises the 16->8 bit

---
 rtl/sc_width_conv_fifo.sv | 115 +++++++++++
 1 files changed

// File: rtl/sc_width_conv_fifo.sv
// Single-clock FIFO that accepts WR_W-bit words and returns them as RATIO narrow slices.
// Counts and flags are registered and computed from next-state values, so outputs never depend on requests combinationally.
module sc_width_conv_fifo #(
   parameter int WR_W      = 16,
   parameter int RATIO     = 2,
   parameter int RD_W      = WR_W / RATIO,
   parameter int DEPTH     = 256,
   parameter bit MSB_FIRST = 1'b1,
   parameter int AFULL_TH  = DEPTH - 4,
   parameter int AEMPTY_TH = 4
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [WR_W-1:0]                    data,
   input  logic                               wrreq,
   input  logic                               rdreq,
   output logic [RD_W-1:0]                    q,
   output logic                               wrfull,
   output logic                               wralmost_full,
   output logic [$clog2(DEPTH):0]             wrusedw,
   output logic                               rdempty,
   output logic                               rdalmost_empty,
   output logic [$clog2(DEPTH*RATIO):0]       rdusedw,
   output logic                               overflow,
   output logic                               underflow
);
   localparam int AW  = $clog2(DEPTH);
   localparam int CW  = AW + 1;
   localparam int RCW = $clog2(DEPTH*RATIO) + 1;
   localparam int SW  = (RATIO > 1) ? $clog2(RATIO) : 1;

   logic [WR_W-1:0]             mem [DEPTH];
   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [SW-1:0]               sidx;
   logic                        wr_ok, rd_ok, last_slice;
   logic [CW-1:0]               wr_cnt_nxt;
   logic [RCW-1:0]              rd_cnt_nxt;
   logic [WR_W-1:0]             rd_word;
   logic [RATIO-1:0][RD_W-1:0]  slices;
   logic [RD_W-1:0]             slice;

   // Acceptance is decided purely on the registered flags, never on the same-edge opposite access.
   assign wr_ok      = wrreq & ~wrfull;
   assign rd_ok      = rdreq & ~rdempty;
   assign last_slice = (sidx == SW'(RATIO - 1));

   assign rd_word = mem[rd_ptr];
   for (genvar k = 0; k < RATIO; k++) begin : g_slice
      if (MSB_FIRST) begin : g_msb
         assign slices[k] = rd_word[WR_W-1-k*RD_W -: RD_W];
      end else begin : g_lsb
         assign slices[k] = rd_word[k*RD_W +: RD_W];
      end
   end

   if (RATIO == 1) begin : g_r1
      assign slice = slices[0];
   end else begin : g_rn
      assign slice = slices[sidx];
   end

   always_comb begin
      wr_cnt_nxt = wrusedw;
      rd_cnt_nxt = rdusedw;
      if (wr_ok) begin
         wr_cnt_nxt = wr_cnt_nxt + CW'(1);
         rd_cnt_nxt = rd_cnt_nxt + RCW'(RATIO);
      end
      if (rd_ok) begin
         rd_cnt_nxt = rd_cnt_nxt - RCW'(1);
         if (last_slice) wr_cnt_nxt = wr_cnt_nxt - CW'(1);
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (!rst && wr_ok) mem[wr_ptr] <= data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         sidx           <= '0;
         q              <= '0;
         wrusedw        <= '0;
         rdusedw        <= '0;
         wrfull         <= 1'b0;
         wralmost_full  <= 1'b0;
         rdempty        <= 1'b1;
         rdalmost_empty <= 1'b1;
         overflow       <= 1'b0;
         underflow      <= 1'b0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) begin
            q <= slice;
            if (last_slice) begin
               sidx   <= '0;
               rd_ptr <= rd_ptr + AW'(1);
            end else begin
               sidx <= sidx + SW'(1);
            end
         end
         if (wrreq && wrfull)  overflow  <= 1'b1;
         if (rdreq && rdempty) underflow <= 1'b1;
         wrusedw        <= wr_cnt_nxt;
         rdusedw        <= rd_cnt_nxt;
         wrfull         <= (wr_cnt_nxt == CW'(DEPTH));
         wralmost_full  <= (wr_cnt_nxt >= CW'(AFULL_TH));
         rdempty        <= (rd_cnt_nxt == '0);
         rdalmost_empty <= (rd_cnt_nxt <= RCW'(AEMPTY_TH));
      end
   end
endmodule
